// File: rtl/banked_mem_pkg.sv
// Shared types and address helpers for banked_mem: FSM state encoding and
// bank-select / in-bank index width arithmetic.
package banked_mem_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int sel_w(input int banks);
        return $clog2(banks);
    endfunction

    function automatic int idx_w(input int addr_w, input int banks);
        return addr_w - $clog2(banks);
    endfunction

    // Bank number is the top log2(banks) bits of the word address.
    function automatic int unsigned bank_of(input int unsigned addr, input int addr_w,
                                            input int banks);
        return addr >> idx_w(addr_w, banks);
    endfunction

endpackage

// File: rtl/banked_mem_bank.sv
// One memory bank: byte-lane write port with per-lane enables and a
// registered (synchronous) read port. Lanes may carry an extra parity bit.
module banked_mem_bank #(
    parameter int LANES  = 1,
    parameter int LANE_W = 8,
    parameter int IDX_W  = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [LANES-1:0]        be,
    input  logic [IDX_W-1:0]        widx,
    input  logic [LANES*LANE_W-1:0] wdata,
    input  logic                    re,
    input  logic [IDX_W-1:0]        ridx,
    output logic [LANES*LANE_W-1:0] rdata
);

    logic [LANES*LANE_W-1:0] mem [2**IDX_W];

    // Array and read register are deliberately not reset; the INIT sweep clears contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < LANES; l++) begin
                if (be[l]) begin
                    mem[widx][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
                end
            end
        end
        if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/banked_mem.sv
// Banked single-port word memory with a zeroing sweep after reset.
// Define BANKED_MEM_PARITY_EN to store and check one even-parity bit per byte.
module banked_mem
    import banked_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int BANKS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int SEL_W = sel_w(BANKS);
    localparam int IDX_W = idx_w(ADDR_W, BANKS);
`ifdef BANKED_MEM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam int WORD_W = NB * LANE_W;

    // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers where rsp_valid && rsp_ready, and is held stable until then.

    state_t             state, state_next;
    logic [IDX_W-1:0]   cnt, cnt_next;
    logic               sweep_we;
    logic               accept;
    logic [SEL_W-1:0]   req_bank, rsp_bank;
    logic [IDX_W-1:0]   req_idx;
    logic [WORD_W-1:0]  wword;
    logic [WORD_W-1:0]  rword;
    logic [WORD_W-1:0]  rd_word [BANKS];
    logic [DATA_W-1:0]  rdata_raw;

    assign init_done = (state == ST_RUN);
    assign req_ready = init_done && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign req_bank  = SEL_W'(bank_of(32'(req_addr), ADDR_W, BANKS));
    assign req_idx   = req_addr[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sweep_we   = 1'b0;
        case (state)
            ST_INIT: begin
                sweep_we = 1'b1;
                cnt_next = cnt + IDX_W'(1);
                if (cnt == '1) begin
                    state_next = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    // Sweep writes an all-zero word; zero bytes have zero even parity.
    always_comb begin
        wword = '0;
        for (int l = 0; l < NB; l++) begin
`ifdef BANKED_MEM_PARITY_EN
            wword[l*LANE_W +: LANE_W] = {^req_wdata[l*8 +: 8], req_wdata[l*8 +: 8]};
`else
            wword[l*LANE_W +: LANE_W] = req_wdata[l*8 +: 8];
`endif
        end
        if (sweep_we) begin
            wword = '0;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic bank_hit;
        assign bank_hit = accept && (req_bank == SEL_W'(b));

        banked_mem_bank #(
            .LANES  (NB),
            .LANE_W (LANE_W),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk   (clk),
            .we    (sweep_we || (bank_hit && req_we)),
            .be    (sweep_we ? {NB{1'b1}} : req_be),
            .widx  (sweep_we ? cnt : req_idx),
            .wdata (wword),
            .re    (bank_hit && !req_we),
            .ridx  (req_idx),
            .rdata (rd_word[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_bank  <= '0;
        end else if (accept && !req_we) begin
            rsp_valid <= 1'b1;
            rsp_bank  <= req_bank;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_comb begin
        rword     = rd_word[rsp_bank];
        rdata_raw = '0;
        for (int l = 0; l < NB; l++) begin
            rdata_raw[l*8 +: 8] = rword[l*LANE_W +: 8];
        end
    end

    // Gating by rsp_valid keeps outputs at zero in reset and before the first read.
    assign rsp_rdata = rsp_valid ? rdata_raw : '0;

`ifdef BANKED_MEM_PARITY_EN
    logic err_raw;
    always_comb begin
        err_raw = 1'b0;
        for (int l = 0; l < NB; l++) begin
            err_raw = err_raw | (^rword[l*LANE_W +: LANE_W]);
        end
    end
    assign rsp_err = rsp_valid && err_raw;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
